// File: rtl/ysyx_24090010_gpr_sb_if.sv
// Read, issue and writeback signals of the GPR/scoreboard block.
// The register file takes the slave modport; decode/writeback logic takes the master modport.
interface ysyx_24090010_gpr_sb_if #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NRD  = 2,
  parameter int AW   = (NREG > 1) ? $clog2(NREG) : 1
);
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic                iss_valid;
  logic [AW-1:0]       iss_rd;
  logic                iss_ready;
  logic                wb_valid;
  logic [AW-1:0]       wb_rd;
  logic [XLEN-1:0]     wb_data;

  modport master (
    output rd_addr,
    input  rd_data,
    input  rd_busy,
    output iss_valid,
    output iss_rd,
    input  iss_ready,
    output wb_valid,
    output wb_rd,
    output wb_data
  );

  modport slave (
    input  rd_addr,
    output rd_data,
    output rd_busy,
    input  iss_valid,
    input  iss_rd,
    output iss_ready,
    input  wb_valid,
    input  wb_rd,
    input  wb_data
  );
endinterface

// File: rtl/ysyx_24090010_gpr_sb.sv
// General-purpose register file with a per-register pending-write counter for RAW stalls.
// Define YSYX_24090010_GPR_BYPASS_EN to forward same-cycle writeback data to the read ports.
module ysyx_24090010_gpr_sb #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NRD  = 2,
  parameter int CNTW = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ysyx_24090010_gpr_sb_if.slave bus,
  output logic [XLEN-1:0]       a0,
  output logic                  sb_err
);
  localparam int              AW       = (NREG > 1) ? $clog2(NREG) : 1;
  localparam logic [CNTW-1:0] CNT_MAX  = {CNTW{1'b1}};
  localparam logic [AW:0]     NREG_LIM = (AW+1)'(NREG);

  logic [XLEN-1:0] data_arr [NREG];
  logic [CNTW-1:0] cnt_arr  [NREG];
  logic [NREG-1:0] uflow_vec;
  logic [CNTW-1:0] iss_cnt;
  logic            iss_ready_int;
  logic            iss_fire;
  logic            sb_err_reg;

  function automatic logic in_range(input logic [AW-1:0] a);
    return ({1'b0, a} < NREG_LIM);
  endfunction

  // Issue side: a register whose counter is saturated refuses new reservations.
  always_comb begin
    iss_cnt = '0;
    if (in_range(bus.iss_rd)) begin
      iss_cnt = cnt_arr[bus.iss_rd];
    end
  end

  assign iss_ready_int = (bus.iss_rd == '0) || (iss_cnt != CNT_MAX);
  assign iss_fire      = bus.iss_valid && iss_ready_int && (bus.iss_rd != '0);
  assign bus.iss_ready = iss_ready_int;

  // x0 holds no state at all.
  assign data_arr[0]  = '0;
  assign cnt_arr[0]   = '0;
  assign uflow_vec[0] = 1'b0;

  for (genvar gi = 1; gi < NREG; gi++) begin : g_reg
    localparam logic [AW-1:0] IDX = AW'(gi);

    logic [XLEN-1:0] data_reg;
    logic [CNTW-1:0] cnt_reg;
    logic [CNTW-1:0] cnt_next;
    logic            iss_hit;
    logic            wb_hit;

    assign iss_hit = iss_fire && (bus.iss_rd == IDX);
    assign wb_hit  = bus.wb_valid && (bus.wb_rd == IDX);

    // Issue and writeback to the same register cancel out (+1 -1).
    always_comb begin
      cnt_next = cnt_reg;
      if (iss_hit && !wb_hit) begin
        cnt_next = cnt_reg + CNTW'(1);
      end else if (wb_hit && !iss_hit && (cnt_reg != '0)) begin
        cnt_next = cnt_reg - CNTW'(1);
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        data_reg <= '0;
        cnt_reg  <= '0;
      end else begin
        cnt_reg <= cnt_next;
        if (wb_hit) begin
          data_reg <= bus.wb_data;
        end
      end
    end

    assign data_arr[gi]  = data_reg;
    assign cnt_arr[gi]   = cnt_reg;
    assign uflow_vec[gi] = wb_hit && !iss_hit && (cnt_reg == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_err_reg <= 1'b0;
    end else if (|uflow_vec) begin
      sb_err_reg <= 1'b1;
    end
  end

  assign sb_err = sb_err_reg;

  if (NREG > 10) begin : g_a0
    assign a0 = data_arr[10];
  end else begin : g_no_a0
    assign a0 = '0;
  end

  logic [XLEN-1:0] rd_data_arr [NRD];
  logic [NRD-1:0]  rd_busy_vec;

  for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] stored_data;
    logic [CNTW-1:0] stored_cnt;

    assign addr = bus.rd_addr[gi*AW +: AW];

    always_comb begin
      stored_data = '0;
      stored_cnt  = '0;
      if ((addr != '0) && in_range(addr)) begin
        stored_data = data_arr[addr];
        stored_cnt  = cnt_arr[addr];
      end
    end

`ifdef YSYX_24090010_GPR_BYPASS_EN
    logic fwd;

    assign fwd = bus.wb_valid && (bus.wb_rd == addr) && (addr != '0) && in_range(addr);
    assign rd_data_arr[gi] = fwd ? bus.wb_data : stored_data;
    // Busy reflects the count after this writeback retires; same-cycle issue is ignored.
    assign rd_busy_vec[gi] = fwd ? (stored_cnt > CNTW'(1)) : (stored_cnt != '0);
`else
    assign rd_data_arr[gi] = stored_data;
    assign rd_busy_vec[gi] = (stored_cnt != '0);
`endif
  end

  always_comb begin
    bus.rd_data = '0;
    for (int k = 0; k < NRD; k++) begin
      bus.rd_data[k*XLEN +: XLEN] = rd_data_arr[k];
    end
  end

  assign bus.rd_busy = rd_busy_vec;

endmodule

// File: tb/tb_ysyx_24090010_gpr_sb.sv
// Table-driven check of the GPR/scoreboard: each vector is applied, queued and compared mid-cycle.
module tb_ysyx_24090010_gpr_sb;
  localparam logic [31:0] A = 32'h1234_5678;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] a0;
  logic        sb_err;

  ysyx_24090010_gpr_sb_if #(.XLEN(32), .NREG(32), .NRD(2)) bus ();

  ysyx_24090010_gpr_sb #(.XLEN(32), .NREG(32), .NRD(2), .CNTW(2)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus),
    .a0     (a0),
    .sb_err (sb_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic        iss_v;
    logic [4:0]  iss_rd;
    logic        wb_v;
    logic [4:0]  wb_rd;
    logic [31:0] wb_d;
    logic [31:0] exp_rd0;
    logic [31:0] exp_rd1;
    logic [1:0]  exp_busy;
    logic        exp_ready;
    logic [31:0] exp_a0;
    logic        exp_err;
  } vec_t;

  vec_t tbl[$];
  vec_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(input string nm, input logic [4:0] ra0, input logic [4:0] ra1,
                              input logic iv, input logic [4:0] ird,
                              input logic wv, input logic [4:0] wrd, input logic [31:0] wd,
                              input logic [31:0] e0, input logic [31:0] e1, input logic [1:0] eb,
                              input logic erdy, input logic [31:0] ea0, input logic eerr);
    vec_t v;
    v.name = nm;   v.ra0 = ra0;   v.ra1 = ra1;
    v.iss_v = iv;  v.iss_rd = ird;
    v.wb_v = wv;   v.wb_rd = wrd; v.wb_d = wd;
    v.exp_rd0 = e0; v.exp_rd1 = e1; v.exp_busy = eb;
    v.exp_ready = erdy; v.exp_a0 = ea0; v.exp_err = eerr;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    vec_t e;
    @(negedge clk);
    bus.rd_addr   = {v.ra1, v.ra0};
    bus.iss_valid = v.iss_v;
    bus.iss_rd    = v.iss_rd;
    bus.wb_valid  = v.wb_v;
    bus.wb_rd     = v.wb_rd;
    bus.wb_data   = v.wb_d;
    sb_q.push_back(v);
    #2;
    e = sb_q.pop_front();
    check({e.name, ".rd0"},   bus.rd_data[31:0],  e.exp_rd0);
    check({e.name, ".rd1"},   bus.rd_data[63:32], e.exp_rd1);
    check({e.name, ".busy"},  {30'd0, bus.rd_busy}, {30'd0, e.exp_busy});
    check({e.name, ".ready"}, {31'd0, bus.iss_ready}, {31'd0, e.exp_ready});
    check({e.name, ".a0"},    a0, e.exp_a0);
    check({e.name, ".err"},   {31'd0, sb_err}, {31'd0, e.exp_err});
    $display("vec %-14s rd0=%08h rd1=%08h busy=%b rdy=%b a0=%08h err=%b",
             e.name, bus.rd_data[31:0], bus.rd_data[63:32], bus.rd_busy, bus.iss_ready, a0, sb_err);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.rd_addr = '0; bus.iss_valid = 1'b0; bus.iss_rd = '0;
    bus.wb_valid = 1'b0; bus.wb_rd = '0; bus.wb_data = '0;

    //              name           ra0 ra1 iv ird wv wrd wdata         rd0           rd1  busy  rdy a0 err
    tbl.push_back(mk("idle",         5, 10, 0, 0,  0, 0,  32'h0,        32'h0,        32'h0, 2'b00, 1, 0, 0));
    tbl.push_back(mk("iss10",       10,  0, 1, 10, 0, 0,  32'h0,        32'h0,        32'h0, 2'b00, 1, 0, 0));
    tbl.push_back(mk("wb10",         3,  0, 0, 0,  1, 10, A,            32'h0,        32'h0, 2'b00, 1, 0, 0));
    tbl.push_back(mk("rd10_wbx0",   10,  0, 0, 0,  1, 0,  32'hFFFFFFFF, A,            32'h0, 2'b00, 1, A, 0));
    tbl.push_back(mk("rd_x0",        0, 10, 0, 0,  0, 0,  32'h0,        32'h0,        A,     2'b00, 1, A, 0));
    tbl.push_back(mk("iss3a",        3,  0, 1, 3,  0, 0,  32'h0,        32'h0,        32'h0, 2'b00, 1, A, 0));
    tbl.push_back(mk("iss3b",        3,  0, 1, 3,  0, 0,  32'h0,        32'h0,        32'h0, 2'b01, 1, A, 0));
    tbl.push_back(mk("iss3c",        3,  0, 1, 3,  0, 0,  32'h0,        32'h0,        32'h0, 2'b01, 1, A, 0));
    tbl.push_back(mk("iss3_full",    3,  0, 1, 3,  0, 0,  32'h0,        32'h0,        32'h0, 2'b01, 0, A, 0));
    tbl.push_back(mk("wb3a",        10,  0, 0, 3,  1, 3,  32'h33,       A,            32'h0, 2'b00, 0, A, 0));
    tbl.push_back(mk("rd3_cnt2",     3,  0, 0, 3,  0, 0,  32'h0,        32'h33,       32'h0, 2'b01, 1, A, 0));
    tbl.push_back(mk("wb3b",         0,  0, 0, 3,  1, 3,  32'h34,       32'h0,        32'h0, 2'b00, 1, A, 0));
    tbl.push_back(mk("rd3_cnt1",     3,  0, 0, 3,  0, 0,  32'h0,        32'h34,       32'h0, 2'b01, 1, A, 0));
    tbl.push_back(mk("wb3c",         0,  0, 0, 3,  1, 3,  32'h35,       32'h0,        32'h0, 2'b00, 1, A, 0));
    tbl.push_back(mk("rd3_clr",      3,  3, 0, 3,  0, 0,  32'h0,        32'h35,       32'h35, 2'b00, 1, A, 0));
    tbl.push_back(mk("iss7",         7,  0, 1, 7,  0, 0,  32'h0,        32'h0,        32'h0, 2'b00, 1, A, 0));
    tbl.push_back(mk("iss_wb7_c1",   0,  0, 1, 7,  1, 7,  32'h77,       32'h0,        32'h0, 2'b00, 1, A, 0));
    tbl.push_back(mk("rd7_c1",       7,  0, 0, 7,  0, 0,  32'h0,        32'h77,       32'h0, 2'b01, 1, A, 0));
    tbl.push_back(mk("wb7",          0,  0, 0, 0,  1, 7,  32'h78,       32'h0,        32'h0, 2'b00, 1, A, 0));
    tbl.push_back(mk("iss_wb7_c0",   0,  0, 1, 7,  1, 7,  32'h79,       32'h0,        32'h0, 2'b00, 1, A, 0));
    tbl.push_back(mk("rd7_c0",       7,  0, 0, 0,  0, 0,  32'h0,        32'h79,       32'h0, 2'b00, 1, A, 0));
    tbl.push_back(mk("wb4_uflow",    0,  0, 0, 0,  1, 4,  32'h44,       32'h0,        32'h0, 2'b00, 1, A, 0));
    tbl.push_back(mk("rd4_iss4",     4,  0, 1, 4,  0, 0,  32'h0,        32'h44,       32'h0, 2'b00, 1, A, 1));
    tbl.push_back(mk("wb4_legal",    0,  7, 0, 0,  1, 4,  32'h45,       32'h0,        32'h79, 2'b00, 1, A, 1));
    tbl.push_back(mk("rd4_sticky",   4,  0, 0, 0,  0, 0,  32'h0,        32'h45,       32'h0, 2'b00, 1, A, 1));
    tbl.push_back(mk("iss9",         0,  0, 1, 9,  0, 0,  32'h0,        32'h0,        32'h0, 2'b00, 1, A, 1));
`ifdef YSYX_24090010_GPR_BYPASS_EN
    tbl.push_back(mk("wb9_same",     9,  0, 0, 0,  1, 9,  32'hA5A5A5A5, 32'hA5A5A5A5, 32'h0, 2'b00, 1, A, 1));
`else
    tbl.push_back(mk("wb9_same",     9,  0, 0, 0,  1, 9,  32'hA5A5A5A5, 32'h0,        32'h0, 2'b01, 1, A, 1));
`endif
    tbl.push_back(mk("rd9",          9,  0, 0, 0,  0, 0,  32'h0,        32'hA5A5A5A5, 32'h0, 2'b00, 1, A, 1));
    tbl.push_back(mk("iss5a",        0,  0, 1, 5,  0, 0,  32'h0,        32'h0,        32'h0, 2'b00, 1, A, 1));
    tbl.push_back(mk("iss5b",        0,  0, 1, 5,  0, 0,  32'h0,        32'h0,        32'h0, 2'b00, 1, A, 1));
    tbl.push_back(mk("wb5",          0,  0, 0, 0,  1, 5,  32'hDEAD,     32'h0,        32'h0, 2'b00, 1, A, 1));

    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      run_vec(tbl[i]);
    end

    // Asynchronous reset in the middle of a cycle with x5 still pending and sb_err set.
    @(negedge clk);
    bus.rd_addr   = {5'd10, 5'd5};
    bus.iss_valid = 1'b0;
    bus.iss_rd    = 5'd5;
    bus.wb_valid  = 1'b0;
    #1;
    check("pre_rst.rd0",  bus.rd_data[31:0], 32'hDEAD);
    check("pre_rst.busy", {30'd0, bus.rd_busy}, 32'd1);
    check("pre_rst.err",  {31'd0, sb_err}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst.rd0",   bus.rd_data[31:0], 32'h0);
    check("rst.rd1",   bus.rd_data[63:32], 32'h0);
    check("rst.busy",  {30'd0, bus.rd_busy}, 32'd0);
    check("rst.ready", {31'd0, bus.iss_ready}, 32'd1);
    check("rst.a0",    a0, 32'h0);
    check("rst.err",   {31'd0, sb_err}, 32'd0);
    $display("vec %-14s rd0=%08h rd1=%08h busy=%b rdy=%b a0=%08h err=%b",
             "async_rst", bus.rd_data[31:0], bus.rd_data[63:32], bus.rd_busy, bus.iss_ready, a0, sb_err);
    @(negedge clk);
    rst_n = 1'b1;

    // Writeback left in flight across reset hits a zero count.
    run_vec(mk("wb5_post_rst", 0, 0, 0, 0, 1, 5, 32'hBEEF, 32'h0,    32'h0, 2'b00, 1, 32'h0, 0));
    run_vec(mk("rd5_err",      5, 0, 0, 0, 0, 0, 32'h0,    32'hBEEF, 32'h0, 2'b00, 1, 32'h0, 1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
